// File: rtl/m_uart_pkg.sv
// Shared constants for the 16x-oversampled UART receiver: FSM encodings,
// sample/decision tick indices and the majority helper.
package m_uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam logic [3:0] SAMPLE_A   = 4'd7;
    localparam logic [3:0] SAMPLE_B   = 4'd8;
    localparam logic [3:0] SAMPLE_C   = 4'd9;
    localparam logic [3:0] DECIDE_IDX = SAMPLE_C;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/m_rx_filter.sv
// Line conditioning for the UART receiver: 2-FF synchronizer, registered
// falling-edge detector and 3-sample majority voter around the bit centre.
module m_rx_filter
    import m_uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baud16_tick,
    input  logic [3:0] tcnt,
    input  logic       rxd,
    output logic       rxd_sync,
    output logic       edge_fall,
    output logic       bit_vote
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;
    logic fall_q, fall_d;
    logic samp_a_q, samp_a_d;
    logic samp_b_q, samp_b_d;

    always_comb begin
        sync1_d  = rxd;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        fall_d   = prev_q & ~sync2_q;
        samp_a_d = samp_a_q;
        samp_b_d = samp_b_q;
        if (baud16_tick && tcnt == SAMPLE_A) samp_a_d = sync2_q;
        if (baud16_tick && tcnt == SAMPLE_B) samp_b_d = sync2_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_q   <= 1'b1;
            fall_q   <= 1'b0;
            samp_a_q <= 1'b1;
            samp_b_q <= 1'b1;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            fall_q   <= fall_d;
            samp_a_q <= samp_a_d;
            samp_b_q <= samp_b_d;
        end
    end

    assign rxd_sync  = sync2_q;
    assign edge_fall = fall_q;
    // Third sample is the live synchronized line, taken on the deciding tick.
    assign bit_vote  = maj3(samp_a_q, samp_b_q, sync2_q);

endmodule

// File: rtl/m_uart_rx.sv
// UART receiver, 1 start / DATA_BITS data LSB-first / optional parity / 1 stop,
// 16x oversampled on baud16_tick. Parity is compiled in by M_UART_RX_PARITY_EN.
module m_uart_rx
    import m_uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 baud16_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic [2:0]           state_q, state_d;
    logic [3:0]           tcnt_q, tcnt_d;
    logic [2:0]           bidx_q, bidx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
`ifdef M_UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 perr_q, perr_d;
`endif

    logic rxd_sync;
    logic edge_fall;
    logic bit_vote;
    logic decide;

    m_rx_filter u_filter (
        .clk         (clk),
        .reset_n     (reset_n),
        .baud16_tick (baud16_tick),
        .tcnt        (tcnt_q),
        .rxd         (rxd),
        .rxd_sync    (rxd_sync),
        .edge_fall   (edge_fall),
        .bit_vote    (bit_vote)
    );

    assign decide = baud16_tick && (tcnt_q == DECIDE_IDX);

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bidx_d  = bidx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef M_UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        if (state_q != ST_IDLE && baud16_tick) tcnt_d = tcnt_q + 4'd1;

        case (state_q)
            ST_IDLE: begin
                // Only a fresh high-to-low edge starts a frame; a held-low line is ignored.
                if (edge_fall && rxd_sync == 1'b0) begin
                    state_d = ST_START;
                    tcnt_d  = 4'd0;
                end
            end
            ST_START: begin
                if (decide) begin
                    if (bit_vote) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        bidx_d  = 3'd0;
                    end
                end
            end
            ST_DATA: begin
                if (decide) begin
                    shift_d = {bit_vote, shift_q[DATA_BITS-1:1]};
                    if (bidx_q == LAST_BIT) begin
`ifdef M_UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bidx_d = bidx_q + 3'd1;
                    end
                end
            end
`ifdef M_UART_RX_PARITY_EN
            ST_PARITY: begin
                if (decide) begin
                    par_bad_d = bit_vote ^ (^shift_q) ^ PARITY_ODD[0];
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (decide) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    ferr_d  = ~bit_vote;
`ifdef M_UART_RX_PARITY_EN
                    perr_d  = par_bad_q;
`endif
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            tcnt_q  <= 4'd0;
            bidx_q  <= 3'd0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef M_UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bidx_q  <= bidx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef M_UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_busy      = (state_q != ST_IDLE);
`ifdef M_UART_RX_PARITY_EN
    assign rx_parity_err = perr_q;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_m_uart_rx.sv
// Bench for m_uart_rx: table of directed frames, hand sequences for false start,
// break and mid-frame reset, then random frames checked against a frame-level model.
module tb_m_uart_rx;

`ifdef M_UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int PARITY_ODD = 0;
    localparam int LAT = PAR ? 170 : 154;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       baud16_tick = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err, rx_parity_err, rx_busy;

    m_uart_rx #(.DATA_BITS(8), .PARITY_ODD(PARITY_ODD)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .baud16_tick   (baud16_tick),
        .rxd           (rxd),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err),
        .rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       pbad;
        int         glitch;
        int         gap;
        int         brk;
        logic [7:0] exp_data;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   tick_gap = 4;
    int   lat_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Tick generator plus output monitor; everything sampled on the falling edge.
    initial begin
        int   gap_cnt;
        exp_t e;
        gap_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (rx_valid) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_valid: got rx_data 0x%0h, expected no frame", rx_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_data", int'(rx_data), int'(e.data));
                        check("frame_err", int'(rx_frame_err), int'(e.ferr));
                        check("parity_err", int'(rx_parity_err), int'(e.perr));
                        check("latency_ticks", lat_cnt, LAT);
                    end
                end else if (rx_frame_err || rx_parity_err) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL err_without_valid: got ferr %0b perr %0b, expected 0", rx_frame_err, rx_parity_err);
                end
            end
            if (!rx_busy) lat_cnt = 0;
            if (gap_cnt + 1 >= tick_gap) begin
                baud16_tick = 1'b1;
                gap_cnt = 0;
            end else begin
                baud16_tick = 1'b0;
                gap_cnt++;
            end
            if (baud16_tick && rx_busy) lat_cnt++;
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!baud16_tick) @(posedge clk);
        end
        #1;
    endtask

    // Spec-level model: line parity bit and expected flags from the frame contents.
    function automatic logic par_line(input logic [7:0] d, input logic pbad);
        return (^d) ^ PARITY_ODD[0] ^ pbad;
    endfunction

    function automatic exp_t model(input logic [7:0] d, input logic stop, input logic pbad);
        exp_t e;
        int   ones;
        ones   = $countones(d) + int'(par_line(d, pbad));
        e.data = d;
        e.ferr = ~stop;
        e.perr = PAR ? ((ones % 2) != PARITY_ODD) : 1'b0;
        return e;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbad, input int glitch);
        rxd = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            if (i == glitch) begin
                wait_ticks(8);
                rxd = ~d[i];
                wait_ticks(1);
                rxd = d[i];
                wait_ticks(7);
            end else begin
                wait_ticks(16);
            end
        end
        if (PAR) begin
            rxd = par_line(d, pbad);
            wait_ticks(16);
        end
        rxd = stop;
        wait_ticks(16);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200_000_000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[7];
        exp_t e;
        logic [7:0] d;
        logic st, pb;

        tbl[0] = '{8'hA5, 1'b1, 1'b0, -1, 4, 0,  8'hA5, 1'b0, 1'b0};
        tbl[1] = '{8'h00, 1'b1, 1'b0,  3, 4, 0,  8'h00, 1'b0, 1'b0};
        tbl[2] = '{8'hFF, 1'b1, 1'b0, -1, 1, 0,  8'hFF, 1'b0, 1'b0};
        tbl[3] = '{8'h3C, 1'b0, 1'b0, -1, 3, 40, 8'h3C, 1'b1, 1'b0};
        tbl[4] = '{8'h55, 1'b1, 1'b0, -1, 2, 0,  8'h55, 1'b0, 1'b0};
        tbl[5] = '{8'h81, 1'b1, 1'b0, -1, 4, 0,  8'h81, 1'b0, 1'b0};
        tbl[6] = '{8'h81, 1'b1, 1'b1, -1, 4, 0,  8'h81, 1'b0, 1'b1};

        #1 reset_n = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_rx_valid", int'(rx_valid), 0);
        check("reset_rx_busy", int'(rx_busy), 0);
        check("reset_frame_err", int'(rx_frame_err), 0);
        check("reset_parity_err", int'(rx_parity_err), 0);
        reset_n = 1'b1;
        wait_ticks(10);

        foreach (tbl[i]) begin
            tick_gap = tbl[i].gap;
            wait_ticks(3);
            e.data = tbl[i].exp_data;
            e.ferr = tbl[i].exp_ferr;
            e.perr = PAR ? tbl[i].exp_perr : 1'b0;
            exp_q.push_back(e);
            send_frame(tbl[i].data, tbl[i].stop, tbl[i].pbad, tbl[i].glitch);
            if (tbl[i].brk > 0) begin
                wait_ticks(tbl[i].brk);
                check("break_no_retrigger", int'(rx_busy), 0);
            end
            rxd = 1'b1;
            wait_ticks(8);
            drain("table_frame_delivered");
        end

        // False start: low for 4 ticks only.
        tick_gap = 4;
        rxd = 1'b0;
        wait_ticks(4);
        check("false_start_busy_high", int'(rx_busy), 1);
        rxd = 1'b1;
        wait_ticks(20);
        check("false_start_busy_low", int'(rx_busy), 0);

        // Reset in the middle of data bit 4, then a clean 0x55.
        d = 8'hF0;
        rxd = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            rxd = d[i];
            wait_ticks(16);
        end
        rxd = d[4];
        wait_ticks(8);
        check("midframe_busy", int'(rx_busy), 1);
        @(negedge clk);
        reset_n = 1'b0;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_rx_data", int'(rx_data), 0);
        check("midrst_rx_valid", int'(rx_valid), 0);
        check("midrst_rx_busy", int'(rx_busy), 0);
        check("midrst_errs", int'({rx_frame_err, rx_parity_err}), 0);
        reset_n = 1'b1;
        wait_ticks(20);
        exp_q.push_back(model(8'h55, 1'b1, 1'b0));
        send_frame(8'h55, 1'b1, 1'b0, -1);
        rxd = 1'b1;
        wait_ticks(8);
        drain("post_reset_frame_delivered");

        // Random frames against the frame-level model.
        for (int k = 0; k < 20; k++) begin
            d  = 8'($urandom);
            st = ($urandom_range(0, 7) != 0);
            pb = 1'($urandom_range(0, 1));
            tick_gap = $urandom_range(1, 4);
            wait_ticks(2);
            exp_q.push_back(model(d, st, pb));
            send_frame(d, st, pb, -1);
            rxd = 1'b1;
            wait_ticks($urandom_range(3, 20));
            drain("random_frame_delivered");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
